dram_frame_unpacker: RTL and testbench

//  Reads a stored camera frame back out of DRAM and unpacks it into a 24-bit pixel stream.

---
 rtl/dram_frame_unpacker.sv | 142 ++++++++++++++
 tb/tb_dram_frame_unpacker.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_frame_unpacker.sv
// Frame read-back: fetches 3-beat groups from DRAM and streams out packed 24-bit pixels.
// One outstanding single-beat read at a time; all outputs registered.
module dram_frame_unpacker #(
    parameter int DRAM_ADDR_WIDTH = 48,
    parameter int DRAM_DATA_WIDTH = 512,
    parameter int PIXEL_WIDTH     = 24,
    parameter int FRAME_CNT_WIDTH = 24
) (
    input  logic                       m_axi_aclk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [DRAM_ADDR_WIDTH-1:0] frame_base_addr,
    input  logic [FRAME_CNT_WIDTH-1:0] frame_pixels,
    output logic                       busy,
    output logic                       done,
    output logic                       dram_read_en,
    output logic [DRAM_ADDR_WIDTH-1:0] dram_read_addr,
    output logic [7:0]                 dram_read_len,
    input  logic                       dram_read_busy,
    input  logic                       dram_read_valid,
    input  logic [DRAM_DATA_WIDTH-1:0] dram_read_data,
    output logic [PIXEL_WIDTH-1:0]     pixel_data,
    output logic                       pixel_valid,
    input  logic                       pixel_ready,
    output logic                       pixel_last
);

    localparam int GROUP_BITS    = 3 * DRAM_DATA_WIDTH;
    localparam int PIX_PER_GROUP = GROUP_BITS / PIXEL_WIDTH;
    localparam int PIX_IDX_W     = $clog2(PIX_PER_GROUP);
    localparam logic [DRAM_ADDR_WIDTH-1:0] BEAT_BYTES =
        DRAM_ADDR_WIDTH'(DRAM_DATA_WIDTH / 8);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, DONE} state_t;

    state_t                     state;
    logic [DRAM_DATA_WIDTH-1:0] beat_q [3];
    logic [1:0]                 beat_idx;
    logic [PIX_IDX_W-1:0]       pix_idx;
    logic [PIX_IDX_W-1:0]       pix_nxt;
    logic [FRAME_CNT_WIDTH-1:0] remaining;
    logic [DRAM_ADDR_WIDTH-1:0] addr;
    logic [GROUP_BITS-1:0]      group;
    logic [PIXEL_WIDTH-1:0]     pix [PIX_PER_GROUP];
    logic                       group_end;

    assign group          = {beat_q[2], beat_q[1], beat_q[0]};
    assign dram_read_addr = addr;
    assign dram_read_len  = 8'h00;
    assign pix_nxt        = pix_idx + PIX_IDX_W'(1);
    assign group_end      = (pix_idx == PIX_IDX_W'(PIX_PER_GROUP - 1)) ||
                            (remaining == FRAME_CNT_WIDTH'(1));

    always_comb begin
        for (int i = 0; i < PIX_PER_GROUP; i++) begin
            pix[i] = group[i*PIXEL_WIDTH +: PIXEL_WIDTH];
        end
    end

    // The first request is issued straight from IDLE so it lands one cycle after start.
    always_ff @(posedge m_axi_aclk) begin
        if (reset) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            dram_read_en <= 1'b0;
            addr         <= '0;
            beat_idx     <= '0;
            pix_idx      <= '0;
            remaining    <= '0;
            pixel_data   <= '0;
            pixel_valid  <= 1'b0;
            pixel_last   <= 1'b0;
            for (int i = 0; i < 3; i++) beat_q[i] <= '0;
        end else begin
            done         <= 1'b0;
            dram_read_en <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        busy      <= 1'b1;
                        addr      <= frame_base_addr;
                        remaining <= frame_pixels;
                        beat_idx  <= '0;
                        if (frame_pixels == '0) begin
                            state <= DONE;
                        end else if (!dram_read_busy) begin
                            dram_read_en <= 1'b1;
                            state        <= WAIT;
                        end else begin
                            state <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (!dram_read_busy) begin
                        dram_read_en <= 1'b1;
                        state        <= WAIT;
                    end
                end
                WAIT: begin
                    if (dram_read_valid) begin
                        beat_q[beat_idx] <= dram_read_data;
                        addr             <= addr + BEAT_BYTES;
                        if (beat_idx == 2'd2) begin
                            beat_idx    <= '0;
                            pix_idx     <= '0;
                            pixel_valid <= 1'b1;
                            pixel_data  <= pix[0];
                            pixel_last  <= (remaining == FRAME_CNT_WIDTH'(1));
                            state       <= DRAIN;
                        end else begin
                            beat_idx <= beat_idx + 2'd1;
                            state    <= REQ;
                        end
                    end
                end
                DRAIN: begin
                    if (pixel_ready) begin
                        pix_idx <= pix_nxt;
                        if (remaining != '0) remaining <= remaining - FRAME_CNT_WIDTH'(1);
                        if (group_end) begin
                            pixel_valid <= 1'b0;
                            pixel_last  <= 1'b0;
                            state <= (remaining == FRAME_CNT_WIDTH'(1)) ? DONE : REQ;
                        end else begin
                            pixel_data <= pix[pix_nxt];
                            pixel_last <= (remaining == FRAME_CNT_WIDTH'(2));
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_frame_unpacker.sv
// Directed bench for dram_frame_unpacker: DRAM responder model, pixel monitor,
// one task per scenario with inline expected-value checks.
module tb_dram_frame_unpacker;

    logic         clk;
    logic         reset;
    logic         start;
    logic [47:0]  frame_base_addr;
    logic [23:0]  frame_pixels;
    logic         busy;
    logic         done;
    logic         dram_read_en;
    logic [47:0]  dram_read_addr;
    logic [7:0]   dram_read_len;
    logic         dram_read_busy;
    logic         dram_read_valid;
    logic [511:0] dram_read_data;
    logic [23:0]  pixel_data;
    logic         pixel_valid;
    logic         pixel_ready;
    logic         pixel_last;

    logic         resp_valid;
    logic [511:0] resp_data;
    logic         stray_valid;
    logic [511:0] stray_data;

    logic [47:0]  req_q[$];
    logic [23:0]  pix_q[$];
    logic         last_q[$];
    int           done_cnt = 0;
    int           total = 0;
    int           bad = 0;

    assign dram_read_valid = resp_valid | stray_valid;
    assign dram_read_data  = stray_valid ? stray_data : resp_data;

    dram_frame_unpacker dut (
        .m_axi_aclk      (clk),
        .reset           (reset),
        .start           (start),
        .frame_base_addr (frame_base_addr),
        .frame_pixels    (frame_pixels),
        .busy            (busy),
        .done            (done),
        .dram_read_en    (dram_read_en),
        .dram_read_addr  (dram_read_addr),
        .dram_read_len   (dram_read_len),
        .dram_read_busy  (dram_read_busy),
        .dram_read_valid (dram_read_valid),
        .dram_read_data  (dram_read_data),
        .pixel_data      (pixel_data),
        .pixel_valid     (pixel_valid),
        .pixel_ready     (pixel_ready),
        .pixel_last      (pixel_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte j of the beat stored at byte address a.
    function automatic logic [7:0] bval(input logic [47:0] a, input int j);
        logic [7:0] v;
        v = a[13:6] * 8'd29;
        v = v + 8'(j * 3);
        return v ^ a[39:32];
    endfunction

    function automatic logic [511:0] beat_of(input logic [47:0] a);
        logic [511:0] d;
        for (int j = 0; j < 64; j++) d[j*8 +: 8] = bval(a, j);
        return d;
    endfunction

    // Pixel n of a frame = bytes 3k..3k+2 of its 192-byte group, d0 lowest.
    function automatic logic [23:0] exp_pix(input logic [47:0] base, input int n);
        logic [23:0] p;
        logic [47:0] ga;
        int b;
        ga = base + 48'((n / 64) * 192);
        for (int t = 0; t < 3; t++) begin
            b = (n % 64) * 3 + t;
            p[t*8 +: 8] = bval(ga + 48'((b / 64) * 64), b % 64);
        end
        return p;
    endfunction

    initial begin
        logic [47:0] a;
        resp_valid = 1'b0;
        resp_data  = '0;
        forever begin
            @(negedge clk);
            if (dram_read_en && !reset) begin
                a = dram_read_addr;
                req_q.push_back(a);
                repeat (2) @(negedge clk);
                resp_data  = beat_of(a);
                resp_valid = 1'b1;
                @(negedge clk);
                resp_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        #4;
        if (!reset && pixel_valid && pixel_ready) begin
            pix_q.push_back(pixel_data);
            last_q.push_back(pixel_last);
        end
        if (done) done_cnt++;
    end

    task automatic clear_logs();
        req_q.delete();
        pix_q.delete();
        last_q.delete();
    endtask

    task automatic do_start(input logic [47:0] base, input int n);
        @(negedge clk);
        frame_base_addr = base;
        frame_pixels    = 24'(n);
        start           = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int n = 0;
        while (done_cnt == d0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (done_cnt == d0) begin
            bad++;
            $display("FAIL wait_done: got no done pulse, expected one within 3000 cycles");
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || dram_read_en !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got busy=%b done=%b en=%b, expected 0 0 0", busy, done, dram_read_en);
        end
        total++;
        if (pixel_valid !== 1'b0 || pixel_last !== 1'b0 || pixel_data !== 24'h0) begin
            bad++;
            $display("FAIL reset_pix: got v=%b l=%b d=%h, expected 0 0 0", pixel_valid, pixel_last, pixel_data);
        end
        total++;
        if (dram_read_addr !== 48'h0 || dram_read_len !== 8'h0) begin
            bad++;
            $display("FAIL reset_addr: got %h len %h, expected 0 0", dram_read_addr, dram_read_len);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_group();
        logic [47:0] base = 48'h4_0000_0000;
        int d0 = done_cnt;
        clear_logs();
        do_start(base, 64);
        total++;
        if (dram_read_en !== 1'b1 || dram_read_len !== 8'h0) begin
            bad++;
            $display("FAIL full_latency: got en=%b len=%h, expected 1 00", dram_read_en, dram_read_len);
        end
        wait_done(d0);
        repeat (3) @(negedge clk);
        total++;
        if (req_q.size() != 3) begin
            bad++;
            $display("FAIL full_nreq: got %0d, expected 3", req_q.size());
        end
        for (int i = 0; i < req_q.size() && i < 3; i++) begin
            total++;
            if (req_q[i] !== base + 48'(64 * i)) begin
                bad++;
                $display("FAIL full_addr%0d: got %h, expected %h", i, req_q[i], base + 48'(64 * i));
            end
        end
        total++;
        if (pix_q.size() != 64) begin
            bad++;
            $display("FAIL full_npix: got %0d, expected 64", pix_q.size());
        end
        for (int i = 0; i < pix_q.size(); i++) begin
            total++;
            if (pix_q[i] !== exp_pix(base, i) || last_q[i] !== 1'(i == 63)) begin
                bad++;
                $display("FAIL full_pix%0d: got %h last %b, expected %h last %b",
                         i, pix_q[i], last_q[i], exp_pix(base, i), i == 63);
            end
        end
        total++;
        if (done_cnt - d0 != 1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL full_done: got %0d pulses busy=%b, expected 1 0", done_cnt - d0, busy);
        end
    endtask

    task automatic test_partial();
        logic [47:0] base = 48'h0000_0012_3400;
        int d0 = done_cnt;
        clear_logs();
        do_start(base, 100);
        repeat (30) @(negedge clk);
        do_start(48'h0000_0099_0000, 7);
        wait_done(d0);
        repeat (10) @(negedge clk);
        total++;
        if (req_q.size() != 6) begin
            bad++;
            $display("FAIL part_nreq: got %0d, expected 6", req_q.size());
        end
        for (int i = 0; i < req_q.size() && i < 6; i++) begin
            total++;
            if (req_q[i] !== base + 48'(64 * i)) begin
                bad++;
                $display("FAIL part_addr%0d: got %h, expected %h", i, req_q[i], base + 48'(64 * i));
            end
        end
        total++;
        if (pix_q.size() != 100) begin
            bad++;
            $display("FAIL part_npix: got %0d, expected 100", pix_q.size());
        end
        for (int i = 0; i < pix_q.size(); i++) begin
            total++;
            if (pix_q[i] !== exp_pix(base, i) || last_q[i] !== 1'(i == 99)) begin
                bad++;
                $display("FAIL part_pix%0d: got %h last %b, expected %h last %b",
                         i, pix_q[i], last_q[i], exp_pix(base, i), i == 99);
            end
        end
        total++;
        if (done_cnt - d0 != 1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL part_done: got %0d pulses busy=%b, expected 1 0", done_cnt - d0, busy);
        end
    endtask

    task automatic test_backpressure();
        logic [47:0] base = 48'hFFFF_FFFF_FF80;
        int d0 = done_cnt;
        bit fin = 1'b0;
        clear_logs();
        fork
            begin
                do_start(base, 70);
                wait_done(d0);
                fin = 1'b1;
            end
            begin
                logic pv = 1'b0;
                logic pr = 1'b0;
                logic [23:0] pd = '0;
                while (!fin) begin
                    @(negedge clk);
                    pixel_ready = 1'($urandom_range(0, 1));
                    #4;
                    if (pv && !pr) begin
                        total++;
                        if (pixel_valid !== 1'b1 || pixel_data !== pd) begin
                            bad++;
                            $display("FAIL bp_stable: got v=%b d=%h, expected 1 %h", pixel_valid, pixel_data, pd);
                        end
                    end
                    pv = pixel_valid;
                    pr = pixel_ready;
                    pd = pixel_data;
                end
            end
        join
        pixel_ready = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (req_q.size() != 6) begin
            bad++;
            $display("FAIL bp_nreq: got %0d, expected 6", req_q.size());
        end
        for (int i = 0; i < req_q.size() && i < 6; i++) begin
            total++;
            if (req_q[i] !== base + 48'(64 * i)) begin
                bad++;
                $display("FAIL bp_addr%0d: got %h, expected %h", i, req_q[i], base + 48'(64 * i));
            end
        end
        total++;
        if (pix_q.size() != 70) begin
            bad++;
            $display("FAIL bp_npix: got %0d, expected 70", pix_q.size());
        end
        for (int i = 0; i < pix_q.size(); i++) begin
            total++;
            if (pix_q[i] !== exp_pix(base, i) || last_q[i] !== 1'(i == 69)) begin
                bad++;
                $display("FAIL bp_pix%0d: got %h last %b, expected %h last %b",
                         i, pix_q[i], last_q[i], exp_pix(base, i), i == 69);
            end
        end
    endtask

    task automatic test_read_busy();
        logic [47:0] base = 48'h0000_0000_1000;
        int d0 = done_cnt;
        clear_logs();
        dram_read_busy = 1'b1;
        do_start(base, 5);
        repeat (20) @(negedge clk);
        total++;
        if (req_q.size() != 0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL rb_hold: got %0d requests busy=%b, expected 0 1", req_q.size(), busy);
        end
        dram_read_busy = 1'b0;
        @(negedge clk);
        total++;
        if (dram_read_en !== 1'b1 || dram_read_addr !== base) begin
            bad++;
            $display("FAIL rb_release: got en=%b addr=%h, expected 1 %h", dram_read_en, dram_read_addr, base);
        end
        @(negedge clk);
        total++;
        if (dram_read_en !== 1'b0) begin
            bad++;
            $display("FAIL rb_once: got en=%b, expected 0", dram_read_en);
        end
        wait_done(d0);
        repeat (3) @(negedge clk);
        total++;
        if (req_q.size() != 3 || pix_q.size() != 5) begin
            bad++;
            $display("FAIL rb_counts: got %0d req %0d pix, expected 3 5", req_q.size(), pix_q.size());
        end
        for (int i = 0; i < pix_q.size(); i++) begin
            total++;
            if (pix_q[i] !== exp_pix(base, i) || last_q[i] !== 1'(i == 4)) begin
                bad++;
                $display("FAIL rb_pix%0d: got %h last %b, expected %h last %b",
                         i, pix_q[i], last_q[i], exp_pix(base, i), i == 4);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [47:0] base = 48'h0000_0020_0000;
        logic [47:0] base2 = 48'h0000_0030_0040;
        int n = 0;
        int d0;
        clear_logs();
        do_start(base, 64);
        while (pix_q.size() < 10 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (pix_q.size() < 10) begin
            bad++;
            $display("FAIL rm_reach: got %0d pixels, expected at least 10", pix_q.size());
        end
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || pixel_valid !== 1'b0 || pixel_last !== 1'b0 ||
            dram_read_en !== 1'b0 || done !== 1'b0 || pixel_data !== 24'h0) begin
            bad++;
            $display("FAIL rm_outs: got busy=%b v=%b l=%b en=%b done=%b d=%h, expected all 0",
                     busy, pixel_valid, pixel_last, dram_read_en, done, pixel_data);
        end
        reset = 1'b0;
        @(negedge clk);
        stray_data  = {512{1'b1}};
        stray_valid = 1'b1;
        @(negedge clk);
        stray_valid = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b0 || pixel_valid !== 1'b0 || dram_read_en !== 1'b0) begin
            bad++;
            $display("FAIL rm_stray: got busy=%b v=%b en=%b, expected 0 0 0", busy, pixel_valid, dram_read_en);
        end
        clear_logs();
        d0 = done_cnt;
        do_start(base2, 64);
        wait_done(d0);
        repeat (3) @(negedge clk);
        total++;
        if (req_q.size() != 3 || pix_q.size() != 64) begin
            bad++;
            $display("FAIL rm_counts: got %0d req %0d pix, expected 3 64", req_q.size(), pix_q.size());
        end
        for (int i = 0; i < pix_q.size(); i++) begin
            total++;
            if (pix_q[i] !== exp_pix(base2, i) || last_q[i] !== 1'(i == 63)) begin
                bad++;
                $display("FAIL rm_pix%0d: got %h last %b, expected %h last %b",
                         i, pix_q[i], last_q[i], exp_pix(base2, i), i == 63);
            end
        end
    endtask

    task automatic test_zero_frame();
        int d0 = done_cnt;
        clear_logs();
        do_start(48'h0000_0000_8000, 0);
        total++;
        if (done !== 1'b0 || busy !== 1'b1 || dram_read_en !== 1'b0) begin
            bad++;
            $display("FAIL zero_t1: got done=%b busy=%b en=%b, expected 0 1 0", done, busy, dram_read_en);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL zero_t2: got done=%b busy=%b, expected 1 0", done, busy);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL zero_t3: got done=%b, expected 0", done);
        end
        repeat (5) @(negedge clk);
        total++;
        if (req_q.size() != 0 || pix_q.size() != 0 || done_cnt - d0 != 1) begin
            bad++;
            $display("FAIL zero_traffic: got %0d req %0d pix %0d done, expected 0 0 1",
                     req_q.size(), pix_q.size(), done_cnt - d0);
        end
    endtask

    initial begin
        reset           = 1'b1;
        start           = 1'b0;
        frame_base_addr = '0;
        frame_pixels    = '0;
        dram_read_busy  = 1'b0;
        pixel_ready     = 1'b1;
        stray_valid     = 1'b0;
        stray_data      = '0;
        test_reset();
        test_full_group();
        test_partial();
        test_backpressure();
        test_read_busy();
        test_reset_mid();
        test_zero_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
